// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down-counter/timer: state encoding, state width
// and small decode helpers used by the top level.
package down_counter_timer_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN     = 2'd1;
    localparam logic [STATE_W-1:0] ST_HOLD    = 2'd2;
    localparam logic [STATE_W-1:0] ST_EXPIRED = 2'd3;

    // busy is asserted only while counting.
    function automatic logic state_is_busy(input logic [STATE_W-1:0] st);
        return (st == ST_RUN) ? 1'b1 : 1'b0;
    endfunction

    // expired is asserted only in the terminal state.
    function automatic logic state_is_expired(input logic [STATE_W-1:0] st);
        return (st == ST_EXPIRED) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/down_counter_timer_dec.sv
// Combinational decrementer: cnt_dec = cnt_in - 1. The caller guarantees it
// is only used when cnt_in > 1, so the wrap at zero never reaches state.
module down_counter_timer_dec #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_dec
);

    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    // Subtract one from the current count.
    always_comb begin
        cnt_dec = cnt_in - ONE_C;
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer. Counts a loaded value down to zero on qualified
// ticks, pulses tc for one cycle at terminal count, then stops (EXPIRED) or
// reloads from reload_r. Commands are strictly prioritised each edge:
// load > stop > start > tick_en; a lower command is ignored whenever a
// higher one is asserted, even if the higher one has no effect in the
// current state.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic             tick_en,
    output logic [WIDTH-1:0] cnt_out,
    output logic             busy,
    output logic             expired,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO_C = '0;
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] state_nxt_s;
    logic [WIDTH-1:0]   cnt_r;
    logic [WIDTH-1:0]   cnt_nxt_s;
    logic [WIDTH-1:0]   cnt_dec_s;
    logic [WIDTH-1:0]   reload_r;
    logic [WIDTH-1:0]   reload_nxt_s;
    logic               tc_r;
    logic               tc_nxt_s;
    logic               busy_r;
    logic               expired_r;

    down_counter_timer_dec #(
        .WIDTH (WIDTH)
    ) u_dec (
        .cnt_in  (cnt_r),
        .cnt_dec (cnt_dec_s)
    );

    // Next-state, next-count and terminal-count decision for this edge.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        reload_nxt_s = reload_r;
        tc_nxt_s     = 1'b0;

        if (load) begin
            cnt_nxt_s    = load_val;
            reload_nxt_s = load_val;
            state_nxt_s  = ST_IDLE;
        end else if (stop) begin
            if (state_r == ST_RUN) begin
                state_nxt_s = ST_HOLD;
            end else begin
                state_nxt_s = state_r;
            end
        end else if (start) begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (cnt_r != ZERO_C) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_EXPIRED;
                        tc_nxt_s    = 1'b1;
                    end
                end
                ST_EXPIRED: begin
                    if (reload_r != ZERO_C) begin
                        cnt_nxt_s   = reload_r;
                        state_nxt_s = ST_RUN;
                    end else begin
                        tc_nxt_s    = 1'b1;
                    end
                end
                ST_RUN: begin
                    state_nxt_s = ST_RUN;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else if (tick_en && (state_r == ST_RUN)) begin
            if (cnt_r > ONE_C) begin
                cnt_nxt_s = cnt_dec_s;
            end else if (cnt_r == ONE_C) begin
                tc_nxt_s = 1'b1;
                if (auto_reload) begin
                    cnt_nxt_s = reload_r;
                end else begin
                    cnt_nxt_s   = ZERO_C;
                    state_nxt_s = ST_EXPIRED;
                end
            end else begin
                // Zero while running is unreachable; park safely in EXPIRED.
                state_nxt_s = ST_EXPIRED;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, count, reload and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= ZERO_C;
            reload_r  <= ZERO_C;
            tc_r      <= 1'b0;
            busy_r    <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            reload_r  <= reload_nxt_s;
            tc_r      <= tc_nxt_s;
            busy_r    <= state_is_busy(state_nxt_s);
            expired_r <= state_is_expired(state_nxt_s);
        end
    end

    assign cnt_out = cnt_r;
    assign busy    = busy_r;
    assign expired = expired_r;
    assign tc      = tc_r;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios with
// hand-derived expectations plus a randomized run against a behavioural model.
module tb_down_counter_timer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic             tick_en;
    logic [WIDTH-1:0] cnt_out;
    logic             busy;
    logic             expired;
    logic             tc;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode is "idle", "run", "hold" or "expired".
    string m_mode;
    int    m_cnt;
    int    m_rel;
    bit    m_tc;

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .tick_en     (tick_en),
        .cnt_out     (cnt_out),
        .busy        (busy),
        .expired     (expired),
        .tc          (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH+2:0] model_vec();
        logic [WIDTH-1:0] c;
        c = m_cnt[WIDTH-1:0];
        return {c, m_tc, (m_mode == "run"), (m_mode == "expired")};
    endfunction

    function automatic logic [WIDTH+2:0] dut_vec();
        return {cnt_out, tc, busy, expired};
    endfunction

    task automatic model_reset();
        m_mode = "idle";
        m_cnt  = 0;
        m_rel  = 0;
        m_tc   = 1'b0;
    endtask

    // Apply the timer rules to the model for one rising edge.
    task automatic model_edge();
        m_tc = 1'b0;
        if (load) begin
            m_cnt  = int'(load_val);
            m_rel  = int'(load_val);
            m_mode = "idle";
        end else if (stop) begin
            if (m_mode == "run") m_mode = "hold";
        end else if (start) begin
            if (m_mode == "expired") begin
                if (m_rel == 0) m_tc = 1'b1;
                else begin m_cnt = m_rel; m_mode = "run"; end
            end else if (m_mode != "run") begin
                if (m_cnt == 0) begin m_mode = "expired"; m_tc = 1'b1; end
                else m_mode = "run";
            end
        end else if (tick_en && m_mode == "run") begin
            if (m_cnt == 1) begin
                m_tc = 1'b1;
                if (auto_reload) m_cnt = m_rel;
                else begin m_cnt = 0; m_mode = "expired"; end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic set_in(input logic ld, input logic [WIDTH-1:0] v, input logic st,
                          input logic sp, input logic ar, input logic tk);
        load = ld; load_val = v; start = st; stop = sp; auto_reload = ar; tick_en = tk;
    endtask

    // One clock: model follows the edge, outputs are observed 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dut_vec() !== 7'b0) begin
            bad++;
            $display("FAIL reset_state: got %b want %b", dut_vec(), 7'b0);
        end
        rst_n = 1'b1;
        cyc();
        total++;
        if (dut_vec() !== 7'b0) begin
            bad++;
            $display("FAIL reset_idle: got %b want %b", dut_vec(), 7'b0);
        end
    endtask

    task automatic test_one_shot();
        int exp_seq [5] = '{4, 3, 2, 1, 0};
        set_in(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        total++;
        if (cnt_out !== 4'd5 || busy !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_start: cnt=%0d busy=%b want cnt=5 busy=1", cnt_out, busy);
        end
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++;
            if (cnt_out !== exp_seq[i][WIDTH-1:0] || tc !== (i == 4)) begin
                bad++;
                $display("FAIL oneshot_tick%0d: cnt=%0d tc=%b want cnt=%0d tc=%b",
                         i, cnt_out, tc, exp_seq[i], (i == 4));
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            total++;
            if ({cnt_out, tc, busy, expired} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL oneshot_expired: got %b want %b",
                         {cnt_out, tc, busy, expired}, {4'd0, 3'b001});
            end
        end
    endtask

    task automatic test_auto_reload();
        int exp_seq [3] = '{2, 1, 3};
        set_in(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cyc();
            total++;
            if (cnt_out !== exp_seq[i % 3][WIDTH-1:0] || tc !== ((i % 3) == 2) || busy !== 1'b1) begin
                bad++;
                $display("FAIL autoreload_tick%0d: cnt=%0d tc=%b busy=%b want cnt=%0d tc=%b busy=1",
                         i, cnt_out, tc, busy, exp_seq[i % 3], ((i % 3) == 2));
            end
        end
    endtask

    task automatic test_hold();
        set_in(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); repeat (3) cyc();
        set_in(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (cnt_out !== 4'd2 || busy !== 1'b0 || expired !== 1'b0) begin
                bad++;
                $display("FAIL hold_frozen%0d: cnt=%0d busy=%b want cnt=2 busy=0", i, cnt_out, busy);
            end
        end
        set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        total++;
        if (cnt_out !== 4'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_resume: cnt=%0d busy=%b want cnt=2 busy=1", cnt_out, busy);
        end
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
        total++;
        if (cnt_out !== 4'd1 || tc !== 1'b0) begin
            bad++;
            $display("FAIL hold_next_tick: cnt=%0d tc=%b want cnt=1 tc=0", cnt_out, tc);
        end
    endtask

    task automatic test_load_priority();
        set_in(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); repeat (2) cyc();
        set_in(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1); cyc();
        total++;
        if ({cnt_out, tc, busy, expired} !== {4'd9, 3'b000}) begin
            bad++;
            $display("FAIL load_over_start: got %b want %b", {cnt_out, tc, busy, expired}, {4'd9, 3'b000});
        end
    endtask

    task automatic test_boundaries();
        set_in(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        total++;
        if ({tc, busy, expired} !== 3'b101 || cnt_out !== 4'd0) begin
            bad++;
            $display("FAIL zero_start: tc/busy/exp=%b cnt=%0d want 101 cnt=0", {tc, busy, expired}, cnt_out);
        end
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        total++;
        if (tc !== 1'b0 || expired !== 1'b1) begin
            bad++;
            $display("FAIL zero_tc_pulse: tc=%b exp=%b want tc=0 exp=1", tc, expired);
        end
        set_in(1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 14; i >= -3; i--) begin
            cyc();
            total++;
            if (cnt_out !== ((i < 0) ? 4'd0 : 4'(i)) || tc !== (i == 0)) begin
                bad++;
                $display("FAIL max_count_step%0d: cnt=%0d tc=%b want cnt=%0d tc=%b",
                         i, cnt_out, tc, (i < 0) ? 0 : i, (i == 0));
            end
        end
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); repeat (2) cyc();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (dut_vec() !== 7'b0) begin
            bad++;
            $display("FAIL async_reset_clear: got %b want %b", dut_vec(), 7'b0);
        end
        model_reset();
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (dut_vec() !== 7'b0) begin
                bad++;
                $display("FAIL post_reset_idle%0d: got %b want %b", i, dut_vec(), 7'b0);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            cyc();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL random_cycle%0d: got {cnt,tc,busy,exp}=%b want %b", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_hold();
        test_load_priority();
        test_boundaries();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
